// File: rtl/beat_decoder_pkg.sv
// beat_decoder_pkg: shared state encoding, error codes and beat count for the beat decoder
package beat_decoder_pkg;
  localparam int unsigned NBEAT = 8;
  typedef enum logic [1:0] {IDLE, LOCKED, ERROR} state_t;
  typedef enum logic [1:0] {E_NONE = 2'd0, E_MULTI = 2'd1, E_ORDER = 2'd2, E_GAP = 2'd3} err_t;
endpackage

// File: rtl/beat_classify.sv
// beat_classify: combinational T0..T7 sample encoder into zero / multi / one-hot index
module beat_classify
  import beat_decoder_pkg::*;
(
  input  logic [NBEAT-1:0] t,
  output logic             zero,
  output logic             multi,
  output logic [2:0]       idx
);
  assign zero  = t == '0;
  assign multi = (t & (t - 1'b1)) != '0;
  // index of the highest set bit; only meaningful when exactly one bit is set
  always_comb begin
    idx = '0;
    for (int i = 0; i < NBEAT; i++) idx = t[i] ? 3'(i) : idx;
  end
endmodule

// File: rtl/beat_decoder.sv
// beat_decoder: timing-beat tracker with lock FSM and sticky errors; BEAT_DECODER_STATS_EN adds a saturating error counter
module beat_decoder
  import beat_decoder_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int GAP_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             T0,
  input  logic             T1,
  input  logic             T2,
  input  logic             T3,
  input  logic             T4,
  input  logic             T5,
  input  logic             T6,
  input  logic             T7,
  input  logic             clr_err,
  output logic [2:0]       beat,
  output logic             beat_vld,
  output logic             cyc_end,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [7:0]       err_cnt
);
  localparam int GW = $clog2(GAP_MAX + 2);
  state_t state, state_nx;
  logic [GW-1:0] gap, gap_nx;
  logic [2:0] beat_nx, idx;
  logic zero, multi, vld_nx, end_nx, new_err;
  err_t code_nx;
  beat_classify u_cls (
    .t    ({T7, T6, T5, T4, T3, T2, T1, T0}),
    .zero (zero),
    .multi(multi),
    .idx  (idx)
  );
  // next-state and strobe decode; any fault seen while locked diverts to ERROR
  always_comb begin
    state_nx = state;
    gap_nx   = gap;
    beat_nx  = beat;
    vld_nx   = 1'b0;
    end_nx   = 1'b0;
    new_err  = 1'b0;
    code_nx  = E_NONE;
    case (state)
      LOCKED: begin
        if (multi) begin
          new_err = 1'b1;
          code_nx = E_MULTI;
        end else if (zero) begin
          new_err = gap >= GW'(GAP_MAX);
          code_nx = new_err ? E_GAP : E_NONE;
          gap_nx  = new_err ? gap : gap + 1'b1;
        end else if (idx == 3'(beat + 3'd1)) begin
          beat_nx = idx;
          vld_nx  = 1'b1;
          end_nx  = beat == 3'd7;
          gap_nx  = '0;
        end else begin
          new_err = 1'b1;
          code_nx = E_ORDER;
        end
      end
      IDLE, ERROR: begin
        if (!zero && !multi && idx == 3'd0) begin
          state_nx = LOCKED;
          beat_nx  = '0;
          vld_nx   = 1'b1;
          gap_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (new_err) state_nx = ERROR;
  end
  // registered state and outputs; a new error outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      gap      <= '0;
      beat     <= '0;
      beat_vld <= 1'b0;
      cyc_end  <= 1'b0;
      cyc_cnt  <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
      err_code <= E_NONE;
    end else begin
      state    <= state_nx;
      gap      <= gap_nx;
      beat     <= beat_nx;
      beat_vld <= vld_nx;
      cyc_end  <= end_nx;
      cyc_cnt  <= cyc_cnt + CNT_W'(end_nx);
      locked   <= state_nx == LOCKED;
      err      <= new_err | (err & !clr_err);
      err_code <= new_err ? code_nx : clr_err ? E_NONE : err_code;
    end
  end
`ifdef BEAT_DECODER_STATS_EN
  // saturating count of ERROR entries, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst) err_cnt <= '0;
    else if (new_err && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_beat_decoder.sv
// tb_beat_decoder: directed scenarios and random traffic checked against a behavioural beat model
module tb_beat_decoder;
  localparam int CNT_W = 4;
  localparam int GAP_MAX = 3;
`ifdef BEAT_DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, clr_err = 1'b0;
  logic [7:0] t = '0;
  logic [2:0] beat;
  logic beat_vld, cyc_end, locked, err;
  logic [CNT_W-1:0] cyc_cnt;
  logic [1:0] err_code;
  logic [7:0] err_cnt;
  int checks = 0, errors = 0;
  bit m_lock, m_vld, m_end, m_err;
  int m_beat, m_gap, m_cyc, m_code, m_ecnt;

  beat_decoder #(.CNT_W(CNT_W), .GAP_MAX(GAP_MAX)) dut (
    .clk(clk), .rst(rst),
    .T0(t[0]), .T1(t[1]), .T2(t[2]), .T3(t[3]), .T4(t[4]), .T5(t[5]), .T6(t[6]), .T7(t[7]),
    .clr_err(clr_err), .beat(beat), .beat_vld(beat_vld), .cyc_end(cyc_end), .cyc_cnt(cyc_cnt),
    .locked(locked), .err(err), .err_code(err_code), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  wire [20:0] obs = {beat, beat_vld, cyc_end, cyc_cnt, locked, err, err_code, err_cnt};

  function automatic logic [20:0] exp_vec();
    return {3'(m_beat), m_vld, m_end, 4'(m_cyc), m_lock, m_err, 2'(m_code), 8'(m_ecnt)};
  endfunction

  function automatic void model(input logic [7:0] s, input logic c, input logic r);
    int n, code;
    n = $countones(s);
    code = 0;
    m_vld = 0;
    m_end = 0;
    if (!r) begin
      m_lock = 0; m_beat = 0; m_gap = 0; m_cyc = 0; m_err = 0; m_code = 0; m_ecnt = 0;
      return;
    end
    if (!m_lock) begin
      if (s == 8'h01) begin
        m_lock = 1; m_beat = 0; m_vld = 1; m_gap = 0;
      end
    end else if (n > 1) code = 1;
    else if (n == 0) begin
      if (m_gap + 1 > GAP_MAX) code = 3;
      else m_gap++;
    end else if (s == 8'(1 << ((m_beat + 1) % 8))) begin
      if (m_beat == 7) begin
        m_end = 1;
        m_cyc = (m_cyc + 1) % (1 << CNT_W);
      end
      m_beat = (m_beat + 1) % 8;
      m_vld = 1;
      m_gap = 0;
    end else code = 2;
    if (code != 0) begin
      m_lock = 0; m_err = 1; m_code = code;
      if (STATS && m_ecnt < 255) m_ecnt++;
    end else if (c) begin
      m_err = 0; m_code = 0;
    end
  endfunction

  task automatic step(input logic [7:0] s, input logic c, input logic r);
    t = s;
    clr_err = c;
    rst = r;
    @(posedge clk);
    model(s, c, r);
    #1;
  endtask

  task automatic test_reset;
    step(8'h01, 1'b1, 1'b0);
    checks++;
    if (obs !== 21'd0) begin errors++; $display("FAIL reset_zero got=%h want=0", obs); end
    step(8'h08, 1'b0, 1'b1);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL idle_ignore got=%h want=%h", obs, exp_vec()); end
    step(8'hff, 1'b0, 1'b1);
    checks++;
    if (obs !== exp_vec() || err !== 1'b0) begin errors++; $display("FAIL idle_multi got=%h want=%h", obs, exp_vec()); end
  endtask

  task automatic test_rounds;
    int vc = 0;
    step(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      step(8'(1 << (i % 8)), 1'b0, 1'b1);
      vc += int'(beat_vld);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL rounds[%0d] got=%h want=%h", i, obs, exp_vec()); end
    end
    checks++;
    if (vc != 24) begin errors++; $display("FAIL rounds_vld got=%0d want=24", vc); end
    checks++;
    if (cyc_cnt !== 4'd2 || locked !== 1'b1 || err !== 1'b0 || beat !== 3'd7)
      begin errors++; $display("FAIL rounds_end got cyc=%0d lk=%b err=%b beat=%0d want 2/1/0/7", cyc_cnt, locked, err, beat); end
  endtask

  task automatic test_order;
    step(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(8'(1 << i), 1'b0, 1'b1);
    step(8'h20, 1'b0, 1'b1);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd2 || locked !== 1'b0 || beat !== 3'd3 || beat_vld !== 1'b0)
      begin errors++; $display("FAIL order_err got err=%b code=%0d lk=%b beat=%0d vld=%b", err, err_code, locked, beat, beat_vld); end
    step(8'h01, 1'b0, 1'b1);
    checks++;
    if (locked !== 1'b1 || err !== 1'b1 || err_code !== 2'd2 || beat !== 3'd0 || beat_vld !== 1'b1)
      begin errors++; $display("FAIL order_relock got lk=%b err=%b code=%0d beat=%0d vld=%b", locked, err, err_code, beat, beat_vld); end
    step(8'h02, 1'b1, 1'b1);
    checks++;
    if (err !== 1'b0 || err_code !== 2'd0 || locked !== 1'b1 || beat !== 3'd1 || obs !== exp_vec())
      begin errors++; $display("FAIL order_clr got=%h want=%h", obs, exp_vec()); end
  endtask

  task automatic test_multi;
    step(8'h0c, 1'b1, 1'b1);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd1 || beat_vld !== 1'b0 || beat !== 3'd1 || locked !== 1'b0)
      begin errors++; $display("FAIL multi got err=%b code=%0d vld=%b beat=%0d lk=%b", err, err_code, beat_vld, beat, locked); end
  endtask

  task automatic test_gap;
    step(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(8'(1 << i), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);
    step(8'h20, 1'b0, 1'b1);
    checks++;
    if (beat_vld !== 1'b1 || beat !== 3'd5 || err !== 1'b0 || locked !== 1'b1)
      begin errors++; $display("FAIL gap_ok got vld=%b beat=%0d err=%b lk=%b", beat_vld, beat, err, locked); end
    for (int i = 6; i < 13; i++) step(8'(1 << (i % 8)), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);
    checks++;
    if (err !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL gap_3 got err=%b lk=%b want 0/1", err, locked); end
    step(8'h00, 1'b0, 1'b1);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd3 || locked !== 1'b0 || beat !== 3'd4)
      begin errors++; $display("FAIL gap_4 got err=%b code=%0d lk=%b beat=%0d", err, err_code, locked, beat); end
  endtask

  task automatic test_wrap;
    int ec = 0;
    step(8'h00, 1'b0, 1'b0);
    step(8'h01, 1'b0, 1'b1);
    for (int r = 0; r < 16; r++)
      for (int i = 1; i <= 8; i++) begin
        step(8'(1 << (i % 8)), 1'b0, 1'b1);
        ec += int'(cyc_end);
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL wrap[%0d.%0d] got=%h want=%h", r, i, obs, exp_vec()); end
      end
    checks++;
    if (ec != 16 || cyc_cnt !== 4'd0 || cyc_end !== 1'b1)
      begin errors++; $display("FAIL wrap_end got ends=%0d cyc=%0d ce=%b want 16/0/1", ec, cyc_cnt, cyc_end); end
    for (int i = 1; i < 4; i++) step(8'(1 << i), 1'b0, 1'b1);
    step(8'h10, 1'b1, 1'b0);
    checks++;
    if (obs !== 21'd0) begin errors++; $display("FAIL midreset got=%h want=0", obs); end
    step(8'h01, 1'b0, 1'b1);
    checks++;
    if (locked !== 1'b1 || beat_vld !== 1'b1 || beat !== 3'd0 || cyc_cnt !== 4'd0 || cyc_end !== 1'b0)
      begin errors++; $display("FAIL relock got lk=%b vld=%b beat=%0d cyc=%0d ce=%b", locked, beat_vld, beat, cyc_cnt, cyc_end); end
  endtask

  task automatic test_stats;
    logic [7:0] seen = '0;
    step(8'h00, 1'b0, 1'b0);
    step(8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(8'h01, 1'b0, 1'b1);
      step(8'h01, 1'b0, 1'b1);
      seen |= err_cnt;
    end
    checks++;
    if (err_cnt !== (STATS ? 8'd255 : 8'd0) || (!STATS && seen !== 8'd0))
      begin errors++; $display("FAIL stats got=%0d seen=%h want=%0d", err_cnt, seen, STATS ? 255 : 0); end
  endtask

  task automatic test_random;
    logic [7:0] s;
    int a, k;
    step(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 99);
      a = $urandom_range(0, 7);
      if (k < 60) s = m_lock ? 8'(1 << ((m_beat + 1) % 8)) : 8'h01;
      else if (k < 75) s = 8'h00;
      else if (k < 82) s = 8'(1 << a) | 8'(1 << ((a + 1 + $urandom_range(0, 6)) % 8));
      else if (k < 90) s = 8'(1 << a);
      else s = 8'($urandom);
      step(s, $urandom_range(0, 9) == 0, $urandom_range(0, 99) != 0);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random[%0d] t=%h got=%h want=%h", i, s, obs, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_rounds();
    test_order();
    test_multi();
    test_gap();
    test_wrap();
    test_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
